// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
// Source encoding matches y_sel and the mux select (0 = A, 1 = B).
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two sources, the arbiter and the downstream consumer.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_last;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_last;
  logic              b_ready;
  logic              y_valid;
  logic [DATA_W-1:0] y_data;
  logic              y_last;
  logic              y_sel;
  logic              y_ready;

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output y_valid, y_data, y_last, y_sel,
    input  y_ready
  );

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  y_valid, y_data, y_last, y_sel,
    output y_ready
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2to1_d.sv
// Purpose: combinational vector 2:1 mux feeding the arbiter output register.
// Latency: 0 cycles. Backpressure: none, pure datapath.
// sel = 0 passes d0, sel = 1 passes d1.
module mux2to1_d #(
  parameter int W = 9
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Purpose: round-robin 2:1 arbiter with registered output; MUX2_ARB_PKT_LOCK_EN holds grant per packet.
// Latency: 1 cycle from input accept to y_valid, 1 beat/cycle.
// Backpressure: y_valid && !y_ready drops both readies and freezes the output register.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mux2_rr_arbiter_if.slave       bus
);

  logic              load;
  logic              grant_a;
  logic              grant_b;
  logic              accept_a;
  logic              accept_b;
  logic              accept;
  logic              pkt_end;
  logic              lock_a;
  logic              lock_b;
  logic              prio;
  logic [DATA_W:0]   mux_out;

  assign load = !bus.y_valid || bus.y_ready;

`ifdef MUX2_ARB_PKT_LOCK_EN
  arb_state_t state;

  assign lock_a  = (state == LOCK_A);
  assign lock_b  = (state == LOCK_B);
  assign pkt_end = mux_out[DATA_W];
`else
  assign lock_a  = 1'b0;
  assign lock_b  = 1'b0;
  assign pkt_end = 1'b1;
`endif

  // A held lock ignores the other source entirely, even if the owner goes idle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (lock_a) begin
      grant_a = bus.a_valid;
    end else if (lock_b) begin
      grant_b = bus.b_valid;
    end else if (bus.a_valid && bus.b_valid) begin
      grant_a = (prio == SRC_A);
      grant_b = (prio == SRC_B);
    end else begin
      grant_a = bus.a_valid;
      grant_b = bus.b_valid;
    end
  end

  assign bus.a_ready = grant_a && load && !rst;
  assign bus.b_ready = grant_b && load && !rst;
  assign accept_a    = bus.a_valid && bus.a_ready;
  assign accept_b    = bus.b_valid && bus.b_ready;
  assign accept      = accept_a || accept_b;

  mux2to1_d #(
    .W(DATA_W + 1)
  ) u_mux (
    .d0  ({bus.a_last, bus.a_data}),
    .d1  ({bus.b_last, bus.b_data}),
    .sel (grant_b),
    .y   (mux_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.y_valid <= 1'b0;
      bus.y_data  <= '0;
      bus.y_last  <= 1'b0;
      bus.y_sel   <= SRC_A;
      prio        <= SRC_A;
    end else begin
      if (load) begin
        bus.y_valid <= accept;
        if (accept) begin
          bus.y_data <= mux_out[DATA_W-1:0];
          bus.y_last <= mux_out[DATA_W];
          bus.y_sel  <= accept_b ? SRC_B : SRC_A;
        end
      end
      if (accept && pkt_end) begin
        prio <= accept_a ? SRC_B : SRC_A;
      end
    end
  end

`ifdef MUX2_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept_a && !bus.a_last) begin
            state <= LOCK_A;
          end else if (accept_b && !bus.b_last) begin
            state <= LOCK_B;
          end
        end
        LOCK_A:  if (accept_a && bus.a_last) state <= IDLE;
        LOCK_B:  if (accept_b && bus.b_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table, corner sequences, randomized model comparison.
module tb_mux2_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mux2_rr_arbiter_if #(.DATA_W(8)) bif ();

  mux2_rr_arbiter #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       ear;
    logic       ebr;
    logic       eyv;
    logic [7:0] eyd;
    logic       eys;
  } vec_t;

  vec_t vecs[$];

  // behavioural model state: output beat, next-favoured source, packet owner (-1 = none)
  int m_valid, m_data, m_last, m_sel, m_prio, m_owner;
  int acc_a, acc_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl,
                       input logic yr);
    bif.a_valid = av; bif.a_data = ad; bif.a_last = al;
    bif.b_valid = bv; bif.b_data = bd; bif.b_last = bl;
    bif.y_ready = yr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y_valid"}, int'(bif.y_valid), 0);
    chk({tag, "_y_data"},  int'(bif.y_data), 0);
    chk({tag, "_y_last"},  int'(bif.y_last), 0);
    chk({tag, "_y_sel"},   int'(bif.y_sel), 0);
    chk({tag, "_a_ready"}, int'(bif.a_ready), 0);
    chk({tag, "_b_ready"}, int'(bif.b_ready), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_valid = 0; m_data = 0; m_last = 0; m_sel = 0; m_prio = 0; m_owner = -1;
  endtask

  // Compare DUT against the model at the negedge, then advance the model past the next posedge.
  task automatic model_step();
    int load, ga, gb, ea, eb, lock_mode;
`ifdef MUX2_ARB_PKT_LOCK_EN
    lock_mode = 1;
`else
    lock_mode = 0;
`endif
    chk("rnd_y_valid", int'(bif.y_valid), m_valid);
    if (m_valid != 0) begin
      chk("rnd_y_data", int'(bif.y_data), m_data);
      chk("rnd_y_last", int'(bif.y_last), m_last);
      chk("rnd_y_sel",  int'(bif.y_sel), m_sel);
    end
    load = (m_valid == 0 || bif.y_ready) ? 1 : 0;
    ga = 0; gb = 0;
    if (m_owner == 0)                   ga = int'(bif.a_valid);
    else if (m_owner == 1)              gb = int'(bif.b_valid);
    else if (bif.a_valid && bif.b_valid) begin
      if (m_prio == 0) ga = 1; else gb = 1;
    end else begin
      ga = int'(bif.a_valid); gb = int'(bif.b_valid);
    end
    ea = ga & load;
    eb = gb & load;
    chk("rnd_a_ready", int'(bif.a_ready), ea);
    chk("rnd_b_ready", int'(bif.b_ready), eb);
    acc_a = ea; acc_b = eb;
    if (load != 0) begin
      m_valid = ea | eb;
      if (ea != 0) begin m_data = int'(bif.a_data); m_last = int'(bif.a_last); m_sel = 0; end
      if (eb != 0) begin m_data = int'(bif.b_data); m_last = int'(bif.b_last); m_sel = 1; end
    end
    if (ea != 0 || eb != 0) begin
      if (lock_mode == 0 || m_last != 0) begin
        m_prio  = (ea != 0) ? 1 : 0;
        m_owner = -1;
      end else begin
        m_owner = (ea != 0) ? 0 : 1;
      end
    end
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 8'h00, 0, 0);

    // reset state, with a requester asserting valid during reset
    bif.a_valid = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    do_reset();

    // contention, back-pressure, single requester, drain/refill; last=1 so both builds agree
    vecs.push_back('{1, 8'hA0, 1, 8'hB0, 1,  1, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 8'hA1, 1, 8'hB0, 1,  0, 1, 1, 8'hA0, 0});
    vecs.push_back('{1, 8'hA1, 1, 8'hB1, 1,  1, 0, 1, 8'hB0, 1});
    vecs.push_back('{1, 8'hA2, 1, 8'hB1, 1,  0, 1, 1, 8'hA1, 0});
    vecs.push_back('{1, 8'hA2, 1, 8'hB2, 0,  0, 0, 1, 8'hB1, 1});
    vecs.push_back('{1, 8'hA2, 1, 8'hB2, 0,  0, 0, 1, 8'hB1, 1});
    vecs.push_back('{1, 8'hA2, 1, 8'hB2, 0,  0, 0, 1, 8'hB1, 1});
    vecs.push_back('{1, 8'hA2, 1, 8'hB2, 1,  1, 0, 1, 8'hB1, 1});
    vecs.push_back('{0, 8'hA3, 1, 8'hB2, 1,  0, 1, 1, 8'hA2, 0});
    vecs.push_back('{0, 8'hA3, 1, 8'hB3, 1,  0, 1, 1, 8'hB2, 1});
    vecs.push_back('{0, 8'hA3, 1, 8'hB4, 1,  0, 1, 1, 8'hB3, 1});
    vecs.push_back('{0, 8'hA3, 1, 8'hB5, 1,  0, 1, 1, 8'hB4, 1});
    vecs.push_back('{0, 8'hA3, 0, 8'hB6, 1,  0, 0, 1, 8'hB5, 1});
    vecs.push_back('{0, 8'hA3, 0, 8'hB6, 1,  0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 8'hA3, 0, 8'hB6, 0,  1, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 8'hA4, 0, 8'hB6, 0,  0, 0, 1, 8'hA3, 0});
    vecs.push_back('{0, 8'hA4, 0, 8'hB6, 1,  0, 0, 1, 8'hA3, 0});
    vecs.push_back('{0, 8'hA4, 0, 8'hB6, 1,  0, 0, 0, 8'h00, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ad, 1'b1, vecs[i].bv, vecs[i].bd, 1'b1, vecs[i].yr);
      @(negedge clk);
      chk($sformatf("vec%0d_a_ready", i), int'(bif.a_ready), int'(vecs[i].ear));
      chk($sformatf("vec%0d_b_ready", i), int'(bif.b_ready), int'(vecs[i].ebr));
      chk($sformatf("vec%0d_y_valid", i), int'(bif.y_valid), int'(vecs[i].eyv));
      if (vecs[i].eyv) begin
        chk($sformatf("vec%0d_y_data", i), int'(bif.y_data), int'(vecs[i].eyd));
        chk($sformatf("vec%0d_y_sel", i),  int'(bif.y_sel),  int'(vecs[i].eys));
        chk($sformatf("vec%0d_y_last", i), int'(bif.y_last), 1);
      end
      @(posedge clk);
      #1;
    end

    // async reset mid-run: prio is 1 here, so after reset A must win again
    drive(1, 8'hA5, 1, 0, 8'h00, 1, 1);
    @(posedge clk);
    #1;
    drive(1, 8'hA6, 1, 1, 8'hB7, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", int'(bif.a_ready), 1);
    chk("post_rst_b_ready", int'(bif.b_ready), 0);
    @(posedge clk);
    #1;

`ifdef MUX2_ARB_PKT_LOCK_EN
    // 3-beat A packet with B contending: A, A, A, then B
    do_reset();
    begin
      logic [7:0] ad [4];
      logic       al [4];
      int         er_a [4];
      int         ey [5];
      int         es [5];
      ad = '{8'h10, 8'h11, 8'h12, 8'h13};
      al = '{1'b0, 1'b0, 1'b1, 1'b1};
      er_a = '{1, 1, 1, 0};
      ey = '{0, 8'h10, 8'h11, 8'h12, 8'hB9};
      es = '{0, 0, 0, 0, 1};
      for (int k = 0; k < 5; k++) begin
        drive(k < 3, (k < 4) ? ad[k] : 8'h00, (k < 4) ? al[k] : 1'b0, 1, 8'hB9, 1, 1);
        @(negedge clk);
        if (k < 4) begin
          chk($sformatf("lock_a_ready%0d", k), int'(bif.a_ready), er_a[k]);
          chk($sformatf("lock_b_ready%0d", k), int'(bif.b_ready), 1 - er_a[k]);
        end
        if (k > 0) begin
          chk($sformatf("lock_y_data%0d", k), int'(bif.y_data), ey[k]);
          chk($sformatf("lock_y_sel%0d", k),  int'(bif.y_sel), es[k]);
        end
        @(posedge clk);
        #1;
      end
    end
`endif

    // reset while B is mid-packet
    do_reset();
    drive(0, 8'h20, 1, 1, 8'hC0, 0, 1);
    @(negedge clk);
    chk("lockb_first_b_ready", int'(bif.b_ready), 1);
    @(posedge clk);
    #1;
    drive(1, 8'h20, 1, 1, 8'hC1, 0, 1);
    @(negedge clk);
`ifdef MUX2_ARB_PKT_LOCK_EN
    chk("lockb_hold_b_ready", int'(bif.b_ready), 1);
`else
    chk("lockb_hold_a_ready", int'(bif.a_ready), 1);
`endif
    #1 rst = 1'b1;
    #1;
    chk_all_zero("lockb_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("lockb_after_a_ready", int'(bif.a_ready), 1);
    chk("lockb_after_b_ready", int'(bif.b_ready), 0);
    @(posedge clk);
    #1;

    // randomized traffic against the model, sources hold beats until accepted
    do_reset();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    acc_a = 1; acc_b = 1;
    for (int c = 0; c < 3000; c++) begin
      if (acc_a != 0 || !bif.a_valid) begin
        bif.a_valid = ($urandom_range(3) != 0);
        bif.a_data  = 8'($urandom);
        bif.a_last  = ($urandom_range(2) == 0);
      end
      if (acc_b != 0 || !bif.b_valid) begin
        bif.b_valid = ($urandom_range(3) != 0);
        bif.b_data  = 8'($urandom);
        bif.b_last  = ($urandom_range(2) == 0);
      end
      bif.y_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
